// File: rtl/sample_decimator.sv
// Boxcar decimator: averages 2**LOG2_DECIM packed multi-channel samples per window.
// Define SAMPLE_DECIMATOR_ROUND_EN for round-half-up averaging; otherwise the average truncates.
module sample_decimator #(
    parameter int BITS       = 16,
    parameter int COLUMNS    = 2,
    parameter int LOG2_DECIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic                    in_valid,
    input  logic [BITS*COLUMNS-1:0] in_data,
    output logic                    out_valid,
    output logic [BITS*COLUMNS-1:0] out_data,
    output logic [LOG2_DECIM-1:0]   win_count
);
    localparam int SUM_W = BITS + LOG2_DECIM;

    logic [SUM_W-1:0] acc [COLUMNS];
    logic [SUM_W-1:0] sum [COLUMNS];
    logic             closing;

    // Worst-case sum plus the half-LSB rounding term still fits in SUM_W bits.
    function automatic logic [BITS-1:0] scale(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] t;
`ifdef SAMPLE_DECIMATOR_ROUND_EN
        t = s + (SUM_W'(1) << (LOG2_DECIM - 1));
`else
        t = s;
`endif
        t = t >> LOG2_DECIM;
        return t[BITS-1:0];
    endfunction

    assign closing = (win_count == {LOG2_DECIM{1'b1}});

    always_comb begin
        for (int c = 0; c < COLUMNS; c++) begin
            sum[c] = acc[c] + SUM_W'(in_data[BITS*c +: BITS]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '{default: '0};
            win_count <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sync) begin
                // A sync sample opens the new window, even if it would have closed the old one.
                win_count <= in_valid ? LOG2_DECIM'(1) : '0;
                for (int c = 0; c < COLUMNS; c++) begin
                    acc[c] <= in_valid ? SUM_W'(in_data[BITS*c +: BITS]) : '0;
                end
            end else if (in_valid) begin
                if (closing) begin
                    for (int c = 0; c < COLUMNS; c++) begin
                        out_data[BITS*c +: BITS] <= scale(sum[c]);
                        acc[c]                   <= '0;
                    end
                    win_count <= '0;
                    out_valid <= 1'b1;
                end else begin
                    for (int c = 0; c < COLUMNS; c++) begin
                        acc[c] <= sum[c];
                    end
                    win_count <= win_count + LOG2_DECIM'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_decimator.sv
// Self-checking bench for sample_decimator: queue-based window model plus directed literal checks.
module tb_sample_decimator;
    localparam int BITS = 16;
    localparam int COLUMNS = 2;
    localparam int L2D = 4;
    localparam int D = 1 << L2D;
    localparam int W = BITS * COLUMNS;
`ifdef SAMPLE_DECIMATOR_ROUND_EN
    localparam int RAMP0 = 8;
`else
    localparam int RAMP0 = 7;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sync = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [L2D-1:0] win_count;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;

    sample_decimator #(.BITS(BITS), .COLUMNS(COLUMNS), .LOG2_DECIM(L2D)) dut (
        .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .win_count(win_count)
    );

    always #5 clk = ~clk;

    // Reference model: collect the samples of the open window, average when D have arrived.
    logic [W-1:0] win_q[$];
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (sync) begin
                win_q.delete();
                if (in_valid) win_q.push_back(in_data);
            end else if (in_valid) begin
                win_q.push_back(in_data);
                if (win_q.size() == D) begin
                    for (int c = 0; c < COLUMNS; c++) begin
                        longint s;
                        logic [W-1:0] w;
                        s = 0;
                        for (int k = 0; k < D; k++) begin
                            w = win_q[k];
                            s += longint'(w[BITS*c +: BITS]);
                        end
`ifdef SAMPLE_DECIMATOR_ROUND_EN
                        s = s + D / 2;
`endif
                        exp_data[BITS*c +: BITS] = BITS'(s / D);
                    end
                    exp_valid = 1'b1;
                    win_q.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int a, input int b);
        return {BITS'(b), BITS'(a)};
    endfunction

    // Apply one cycle of inputs, step past the edge, and compare every output with the model.
    task automatic cyc(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        sync     = s;
        in_data  = d;
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
        chk("out_valid", out_valid, exp_valid);
        chk("out_data", out_data, exp_data);
        chk("win_count", win_count, win_q.size());
    endtask

    initial begin
        int p1, p2, base;
        p1 = -1;
        p2 = -1;

        cyc(0, 0, '0);
        cyc(0, 0, '0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_win_count", win_count, 0);
        rst = 1'b0;

        // Ramp on ch0, full scale on ch1
        for (int i = 0; i < D; i++) cyc(1, 0, pack(i, 65535));
        chk("ramp_pulse", out_valid, 1);
        chk("ramp_ch0", out_data[15:0], RAMP0);
        chk("ramp_ch1", out_data[31:16], 65535);
        cyc(0, 0, '0);
        chk("ramp_held", out_data, pack(RAMP0, 65535));

        // Same ramp with a gap after every sample
        base = pulses;
        for (int i = 0; i < D; i++) begin
            cyc(1, 0, pack(i, 65535));
            if (i == D - 1) chk("gap_pulse_last", out_valid, 1);
            else cyc(0, 0, '0);
        end
        chk("gap_ch0", out_data[15:0], RAMP0);
        chk("gap_one_pulse", pulses - base, 1);

        // sync mid-window with no sample
        for (int i = 0; i < 9; i++) cyc(1, 0, pack(500, 500));
        chk("pre_sync_count", win_count, 9);
        cyc(0, 1, '0);
        chk("sync_count", win_count, 0);
        chk("sync_no_pulse", out_valid, 0);
        chk("sync_data_kept", out_data, pack(RAMP0, 65535));
        for (int i = 0; i < D; i++) cyc(1, 0, pack(300, 300));
        chk("after_sync", out_data, pack(300, 300));

        // sync coinciding with the closing sample
        for (int i = 0; i < D - 1; i++) cyc(1, 0, pack(10, 10));
        cyc(1, 1, pack(40, 40));
        chk("sync_close_no_pulse", out_valid, 0);
        chk("sync_close_count", win_count, 1);
        chk("sync_close_data", out_data, pack(300, 300));
        for (int i = 0; i < D - 1; i++) cyc(1, 0, pack(40, 40));
        chk("sync_close_avg", out_data, pack(40, 40));
        chk("sync_close_pulse", out_valid, 1);

        // Back-to-back windows
        for (int i = 0; i < 2 * D; i++) begin
            cyc(1, 0, (i < D) ? pack(1000, 1000) : pack(2000, 2000));
            if (out_valid) begin
                if (p1 < 0) p1 = i;
                else p2 = i;
            end
            if (i == 2 * D - 2) chk("b2b_hold", out_data, pack(1000, 1000));
        end
        chk("b2b_first", p1, D - 1);
        chk("b2b_spacing", p2 - p1, D);
        chk("b2b_second", out_data, pack(2000, 2000));

        // Asynchronous reset mid-window
        for (int i = 0; i < 5; i++) cyc(1, 0, pack(123, 123));
        chk("pre_rst_count", win_count, 5);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_win_count", win_count, 0);
        cyc(0, 0, '0);
        rst = 1'b0;
        base = pulses;
        for (int i = 0; i < D; i++) cyc(1, 0, pack(100, 100));
        chk("post_rst_avg", out_data, pack(100, 100));
        chk("post_rst_pulses", pulses - base, 1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
